// File: rtl/lane_adder_pkg.sv
// Shared types and defaults for the lane serial adder.
package lane_adder_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } lsa_state_e;

   localparam int LSA_WIDTH  = 8;
   localparam int LSA_LANE_W = 4;

   // Lane index width; never below one bit even for tiny lane counts.
   function automatic int lane_idx_w(input int nlanes);
      return (nlanes <= 2) ? 1 : $clog2(nlanes);
   endfunction

endpackage

// File: rtl/lane_add_cell.sv
// Combinational LANE_W-bit lane adder with carry-out in the MSB.
// Optional saturation of independent-lane sums under `LANE_SAT_EN.
module lane_add_cell #(
   parameter int LANE_W = 4
) (
   input  logic [LANE_W-1:0] x_i,
   input  logic [LANE_W-1:0] y_i,
   input  logic              cin_i,
`ifdef LANE_SAT_EN
   input  logic              sat_i,
`endif
   output logic [LANE_W:0]   sum_o
);

   logic [LANE_W:0] raw;

   assign raw = {1'b0, x_i} + {1'b0, y_i} + {{LANE_W{1'b0}}, cin_i};

`ifdef LANE_SAT_EN
   // Clamp an overflowing independent lane to all-ones, keeping the overflow flag.
   always_comb begin
      sum_o = raw;
      if (sat_i && raw[LANE_W]) sum_o = {1'b1, {LANE_W{1'b1}}};
   end
`else
   assign sum_o = raw;
`endif

endmodule

// File: rtl/lane_serial_adder.sv
// Lane serial adder: accepts two WIDTH-bit operands, emits one LANE_W-bit
// lane sum per output handshake (LSB lane first), independent or chained.
// Optional build macro: LANE_SAT_EN (saturate independent-lane overflow).
module lane_serial_adder
   import lane_adder_pkg::*;
#(
   parameter int WIDTH  = LSA_WIDTH,
   parameter int LANE_W = LSA_LANE_W,
   parameter int NLANES = WIDTH / LANE_W,
   parameter int IDX_W  = lane_idx_w(NLANES)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  a,
   input  logic [WIDTH-1:0]  b,
   input  logic              ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [IDX_W-1:0]  out_lane,
   output logic [LANE_W:0]   out_sum,
   output logic              out_last,
   output logic [WIDTH:0]    sum_full
);

   lsa_state_e        state_q, state_d;
   // Operand copies are shifted right one lane per step so the next lane
   // always sits in the low LANE_W bits.
   logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
   logic              ctrl_q, ctrl_d;
   logic              carry_q, carry_d;
   logic [IDX_W-1:0]  lane_q, lane_d;
   logic [LANE_W:0]   sum_q, sum_d;
   logic              last_q, last_d;
   logic [WIDTH:0]    full_q, full_d;
   logic              vld_q, vld_d;

   logic              idle, accept, advance, finish;
   logic [LANE_W-1:0] cell_x, cell_y;
   logic              cell_cin, cell_chain;
   logic [LANE_W:0]   cell_sum;
   logic [IDX_W-1:0]  nxt_idx;
   logic [WIDTH:0]    full_base;

   assign idle    = (state_q == IDLE);
   assign accept  = idle && in_valid;
   assign advance = !idle && out_ready && !last_q;
   assign finish  = !idle && out_ready && last_q;

   // Lane 0 is computed straight from the inputs on accept; later lanes use
   // the latched, shifted copies and the previous lane's carry.
   assign cell_x     = idle ? a[LANE_W-1:0] : a_q[LANE_W-1:0];
   assign cell_y     = idle ? b[LANE_W-1:0] : b_q[LANE_W-1:0];
   assign cell_chain = idle ? ctrl : ctrl_q;
   assign cell_cin   = idle ? 1'b0 : (ctrl_q & carry_q);
   assign nxt_idx    = idle ? '0 : IDX_W'(lane_q + 1'b1);
   assign full_base  = idle ? '0 : full_q;

   lane_add_cell #(.LANE_W(LANE_W)) u_cell (
      .x_i   (cell_x),
      .y_i   (cell_y),
      .cin_i (cell_cin),
`ifdef LANE_SAT_EN
      .sat_i (!cell_chain),
`endif
      .sum_o (cell_sum)
   );

   // Next-state: load a lane on accept or advance, drop back to IDLE after the last lane.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      ctrl_d  = ctrl_q;
      carry_d = carry_q;
      lane_d  = lane_q;
      sum_d   = sum_q;
      last_d  = last_q;
      full_d  = full_q;
      vld_d   = vld_q;
      if (accept || advance) begin
         if (accept) begin
            a_d    = a >> LANE_W;
            b_d    = b >> LANE_W;
            ctrl_d = ctrl;
         end else begin
            a_d = a_q >> LANE_W;
            b_d = b_q >> LANE_W;
         end
         carry_d = cell_sum[LANE_W];
         lane_d  = nxt_idx;
         sum_d   = cell_sum;
         last_d  = (nxt_idx == IDX_W'(NLANES - 1));
         full_d  = full_base;
         for (int k = 0; k < NLANES; k++) begin
            if (nxt_idx == IDX_W'(k)) full_d[k*LANE_W +: LANE_W] = cell_sum[LANE_W-1:0];
         end
         full_d[WIDTH] = cell_sum[LANE_W];
         vld_d   = 1'b1;
         state_d = RUN;
      end else if (finish) begin
         vld_d   = 1'b0;
         state_d = IDLE;
      end
   end

   // State and output registers; reset aborts any burst in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         ctrl_q  <= 1'b0;
         carry_q <= 1'b0;
         lane_q  <= '0;
         sum_q   <= '0;
         last_q  <= 1'b0;
         full_q  <= '0;
         vld_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         ctrl_q  <= ctrl_d;
         carry_q <= carry_d;
         lane_q  <= lane_d;
         sum_q   <= sum_d;
         last_q  <= last_d;
         full_q  <= full_d;
         vld_q   <= vld_d;
      end
   end

   assign in_ready  = idle;
   assign out_valid = vld_q;
   assign out_lane  = lane_q;
   assign out_sum   = sum_q;
   assign out_last  = last_q;
   assign sum_full  = full_q;

endmodule
